// File: rtl/mem_rq_router.sv
// Memory request router: accepts one processor request at a time, decodes it
// to on-chip RAM, a small MMIO register window or an error target, and
// returns exactly one response word per accepted request.
module mem_rq_router #(
    parameter int          LGSZW     = 8,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             rq_valid,
    input  logic [64:0]      rq_data,
    output logic             rq_ready,
    output logic             rs_valid,
    output logic [31:0]      rs_data,
    input  logic             rs_ready,
    output logic [LGSZW-1:0] ram_addr,
    output logic             ram_we,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata,
    output logic [7:0]       gpio_out,
    input  logic [7:0]       gpio_in
);

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAM_RD = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] resp_reg, resp_next;
    logic [7:0]  gpio_reg, gpio_next;
    logic [7:0]  errcnt_reg, errcnt_next;
    logic [31:0] cycles_reg;

    // Request fields
    logic [31:0] addr;
    logic        iswrite;
    logic [31:0] wdata;
    logic [1:0]  mmio_off;
    logic        hit_ram;
    logic        hit_mmio;
    logic        accept;
    logic [31:0] mmio_rdata;
    logic        unused_bits;

    assign addr     = rq_data[64:33];
    assign iswrite  = rq_data[32];
    assign wdata    = rq_data[31:0];
    assign mmio_off = addr[3:2];

    // The byte lane bits never select anything: all accesses are full words.
    assign unused_bits = ^addr[1:0];

    // RAM owns the bottom 4*2^LGSZW bytes; MMIO is a 16-byte window. RAM wins
    // if a misconfigured MMIO_BASE ever overlaps it.
    assign hit_ram  = (addr[31:LGSZW+2] == '0);
    assign hit_mmio = !hit_ram && (addr[31:4] == MMIO_BASE[31:4]);

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign rq_ready = RST_N && (state_reg == IDLE);
    assign accept   = rq_valid && rq_ready;

    // RAM port: address follows the request bus continuously so a read
    // accepted this cycle has its data one cycle later.
    assign ram_addr  = rq_data[LGSZW+34:35];
    assign ram_we    = accept && iswrite && hit_ram;
    assign ram_wdata = wdata;

    // Response channel; data is forced to zero whenever it is not valid.
    assign rs_valid = (state_reg == RESP);
    assign rs_data  = rs_valid ? resp_reg : 32'h0;

    assign gpio_out = gpio_reg;

    // MMIO read mux, values taken in the acceptance cycle
    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            2'd0:    mmio_rdata = {24'h0, gpio_reg};
            2'd1:    mmio_rdata = {24'h0, gpio_in};
            2'd2:    mmio_rdata = cycles_reg;
            default: mmio_rdata = {24'h0, errcnt_reg};
        endcase
    end

    // Next-state, response capture and register side effects
    always_comb begin
        state_next  = state_reg;
        resp_next   = resp_reg;
        gpio_next   = gpio_reg;
        errcnt_next = errcnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (hit_ram) begin
                        if (iswrite) begin
                            resp_next  = 32'h0;
                            state_next = RESP;
                        end else begin
                            state_next = RAM_RD;
                        end
                    end else if (hit_mmio) begin
                        state_next = RESP;
                        if (iswrite) begin
                            resp_next = 32'h0;
                            // GPIO_IN and CYCLES are read-only; writes drop silently
                            if (mmio_off == 2'd0) begin
                                gpio_next = wdata[7:0];
                            end else if (mmio_off == 2'd3) begin
                                errcnt_next = 8'h0;
                            end
                        end else begin
                            resp_next = mmio_rdata;
                        end
                    end else begin
                        state_next = RESP;
                        resp_next  = ERR_WORD;
                        if (errcnt_reg != 8'hFF) begin
                            errcnt_next = errcnt_reg + 8'd1;
                        end
                    end
                end
            end
            RAM_RD: begin
                resp_next  = ram_rdata;
                state_next = RESP;
            end
            RESP: begin
                if (rs_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and register update; reset drops any pending response
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg  <= IDLE;
            resp_reg   <= 32'h0;
            gpio_reg   <= 8'h0;
            errcnt_reg <= 8'h0;
        end else begin
            state_reg  <= state_next;
            resp_reg   <= resp_next;
            gpio_reg   <= gpio_next;
            errcnt_reg <= errcnt_next;
        end
    end

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cycles_reg <= 32'h0;
        end else begin
            cycles_reg <= cycles_reg + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_rq_router.sv
// Bench for mem_rq_router: directed vector table, randomized traffic checked
// against a transaction-level model, error saturation and reset-abort cases.
module tb_mem_rq_router;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        rq_valid;
    logic [64:0] rq_data;
    logic        rq_ready;
    logic        rs_valid;
    logic [31:0] rs_data;
    logic        rs_ready;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in;

    int checks = 0;
    int errors = 0;

    mem_rq_router #(.LGSZW(8), .MMIO_BASE(MB)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .rq_valid(rq_valid), .rq_data(rq_data), .rq_ready(rq_ready),
        .rs_valid(rs_valid), .rs_data(rs_data), .rs_ready(rs_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .gpio_out(gpio_out), .gpio_in(gpio_in)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int i);
        return (i == 5) ? 32'h1234_5678 : (32'h5A00_0000 ^ (32'(i) * 32'h0001_0203));
    endfunction

    // Synchronous-read RAM attached to the DUT; preloaded on the first edge
    logic [31:0] tb_mem [256];
    bit preloaded = 1'b0;
    always @(posedge CLK) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
            preloaded <= 1'b1;
        end else if (ram_we) begin
            tb_mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= tb_mem[ram_addr];
    end

    // Reference model state
    logic [31:0] m_mem [256];
    logic [7:0]  m_gpio;
    logic [7:0]  m_err;
    logic [31:0] m_cyc;

    // Elapsed cycles since reset release, as the CYCLES register should see it
    always @(posedge CLK) begin
        if (!RST_N) m_cyc <= 32'h0;
        else        m_cyc <= m_cyc + 32'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One complete request/response transaction with model checking
    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [7:0] gin, input int hold, output logic [31:0] got);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        int          n;
        bit          is_ram;
        bit          is_mmio;
        n = 0;
        while (!rq_ready && n < 20) begin
            step();
            n++;
        end
        chk("rq_ready_wait", rq_ready, 1);
        is_ram  = (addr < 32'd1024);
        is_mmio = !is_ram && (addr >= MB) && (addr < MB + 32'd16);
        gpio_in  = gin;
        rq_valid = 1'b1;
        rq_data  = {addr, wr, wd};
        #1;
        chk("ram_we", ram_we, (is_ram && wr) ? 1 : 0);
        if (is_ram) chk("ram_addr", ram_addr, addr[9:2]);
        exp_lat = (is_ram && !wr) ? 2 : 1;
        exp = 32'h0;
        if (is_ram) begin
            if (wr) m_mem[addr[9:2]] = wd;
            else    exp = m_mem[addr[9:2]];
        end else if (is_mmio) begin
            case (addr[3:2])
                2'd0: if (wr) m_gpio = wd[7:0]; else exp = {24'h0, m_gpio};
                2'd1: if (!wr) exp = {24'h0, gin};
                2'd2: if (!wr) exp = m_cyc;
                default: if (wr) m_err = 8'h0; else exp = {24'h0, m_err};
            endcase
        end else begin
            exp = 32'hDEAD_BEEF;
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        step();
        rq_valid = 1'b0;
        rq_data  = {$urandom, $urandom, 1'b0};
        chk("gpio_out", gpio_out, m_gpio);
        lat = 1;
        while (!rs_valid && lat < 6) begin
            chk("rs_data_idle", rs_data, 0);
            chk("rq_ready_busy", rq_ready, 0);
            step();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rs_data", rs_data, exp);
        got = rs_data;
        for (int h = 0; h < hold; h++) begin
            chk("rq_ready_hold", rq_ready, 0);
            step();
            chk("rs_valid_hold", rs_valid, 1);
            chk("rs_data_hold", rs_data, exp);
        end
        rs_ready = 1'b1;
        step();
        rs_ready = 1'b0;
        chk("rs_valid_after", rs_valid, 0);
        chk("rs_data_after", rs_data, 0);
        chk("rq_ready_after", rq_ready, 1);
        $display("TXN addr=%h wr=%0d wdata=%h rdata=%h exp=%h lat=%0d hold=%0d",
                 addr, wr, wd, got, exp, lat, hold);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [7:0]  gin;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [15];

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        int          kind;

        vt[0]  = '{32'h0000_0020, 1'b1, 32'hCAFE_F00D, 8'h00, 32'h0};
        vt[1]  = '{32'h0000_0020, 1'b0, 32'h0,         8'h00, 32'hCAFE_F00D};
        vt[2]  = '{32'h0000_0014, 1'b0, 32'h0,         8'h00, 32'h1234_5678};
        vt[3]  = '{MB,            1'b1, 32'h0000_00A5, 8'h00, 32'h0};
        vt[4]  = '{MB,            1'b0, 32'h0,         8'h00, 32'h0000_00A5};
        vt[5]  = '{MB + 32'h4,    1'b0, 32'h0,         8'h3C, 32'h0000_003C};
        vt[6]  = '{32'h2000_0000, 1'b0, 32'h0,         8'h00, 32'hDEAD_BEEF};
        vt[7]  = '{32'h2000_0000, 1'b0, 32'h0,         8'h00, 32'hDEAD_BEEF};
        vt[8]  = '{32'h2000_0000, 1'b0, 32'h0,         8'h00, 32'hDEAD_BEEF};
        vt[9]  = '{MB + 32'hC,    1'b0, 32'h0,         8'h00, 32'h3};
        vt[10] = '{MB + 32'hC,    1'b1, 32'h55,        8'h00, 32'h0};
        vt[11] = '{MB + 32'hC,    1'b0, 32'h0,         8'h00, 32'h0};
        vt[12] = '{MB + 32'h4,    1'b1, 32'hFF,        8'h00, 32'h0};
        vt[13] = '{MB + 32'h8,    1'b1, 32'h1234,      8'h00, 32'h0};
        vt[14] = '{MB + 32'hC,    1'b0, 32'h0,         8'h00, 32'h0};

        for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
        m_gpio = 8'h0;
        m_err  = 8'h0;

        // Reset with a RAM write presented: nothing may be accepted
        RST_N    = 1'b0;
        rq_valid = 1'b1;
        rq_data  = {32'h0000_0040, 1'b1, 32'hFFFF_FFFF};
        rs_ready = 1'b0;
        gpio_in  = 8'h0;
        step();
        step();
        chk("rst_rq_ready", rq_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rs_valid", rs_valid, 0);
        chk("rst_rs_data", rs_data, 0);
        chk("rst_gpio", gpio_out, 0);
        step();
        RST_N    = 1'b1;
        rq_valid = 1'b0;
        #1;
        chk("rq_ready_release", rq_ready, 1);

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            do_req(vt[i].addr, vt[i].wr, vt[i].wd, vt[i].gin, (i == 2) ? 5 : 0, got);
            chk($sformatf("vec%0d", i), got, vt[i].exp);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 5)       addr = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
            else if (kind < 8)  addr = MB + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            else if (kind == 8) addr = 32'h2000_0000 | $urandom_range(0, 16'hFFFF);
            else                addr = 32'h0000_0400 + ($urandom_range(0, 255) << 2);
            do_req(addr, 1'($urandom_range(0, 1)), $urandom, 8'($urandom),
                   int'($urandom_range(0, 3)), got);
        end

        // Error counter saturation
        do_req(MB + 32'hC, 1'b1, 32'h0, 8'h0, 0, got);
        for (int i = 0; i < 300; i++) begin
            do_req(32'h2000_0000 + 32'(i * 4), 1'b0, 32'h0, 8'h0, 0, got);
        end
        do_req(MB + 32'hC, 1'b0, 32'h0, 8'h0, 0, got);
        chk("errcnt_sat", got, 32'd255);

        // Reset while a RAM read is in flight
        do_req(MB, 1'b1, 32'h77, 8'h0, 0, got);
        rq_valid = 1'b1;
        rq_data  = {32'h0000_0014, 1'b0, 32'h0};
        step();
        rq_valid = 1'b0;
        RST_N    = 1'b0;
        step();
        chk("rst_rd_rs_valid", rs_valid, 0);
        chk("rst_rd_gpio", gpio_out, 0);
        chk("rst_rd_rq_ready", rq_ready, 0);
        step();
        RST_N  = 1'b1;
        m_gpio = 8'h0;
        m_err  = 8'h0;
        #1;
        chk("rst_rd_release_ready", rq_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_stale_rs_valid", rs_valid, 0);
        end
        do_req(MB + 32'h8, 1'b0, 32'h0, 8'h0, 0, got);
        chk("cycles_small", (got < 32'd16) ? 1 : 0, 1);
        do_req(MB + 32'hC, 1'b0, 32'h0, 8'h0, 0, got);
        do_req(MB, 1'b0, 32'h0, 8'h0, 0, got);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_rq_router.md
MEM_RQ_ROUTER -- requirements
Module: mem_rq_router

Interface
REQ-001 Parameter LGSZW, default 8: log2 of RAM depth in 32-bit words.
REQ-002 Parameter MMIO_BASE, default 32'h1000_0000: base byte address of the MMIO register window.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset, synchronous, active-low.
REQ-005 rq_valid  in  1  processor request present.
REQ-006 rq_data  in  65  request: [64:33] byte address, [32] iswrite, [31:0] write data.
REQ-007 rq_ready  out  1  request accepted this cycle when rq_valid && rq_ready.
REQ-008 rs_valid  out  1  response present.
REQ-009 rs_data  out  32  response word.
REQ-010 rs_ready  in  1  response consumed this cycle when rs_valid && rs_ready.
REQ-011 ram_addr  out  LGSZW  word address to synchronous-read RAM (rq_data[LGSZW+34:35]).
REQ-012 ram_we  out  1  RAM write strobe, full 32-bit word.
REQ-013 ram_wdata  out  32  RAM write data.
REQ-014 ram_rdata  in  32  RAM read data, valid one cycle after the address is presented.
REQ-015 gpio_out  out  8  registered output pins (LED drive).
REQ-016 gpio_in  in  8  input pins, sampled on each MMIO read.

Function
REQ-017 States: IDLE, RAM_RD, RESP; exactly one request outstanding at any time.
REQ-018 rq_ready = 1 only in IDLE; in RAM_RD and RESP it is 0.
REQ-019 Decode on acceptance: RAM if (addr >> (2+LGSZW)) == 0; MMIO if addr[31:4] == MMIO_BASE[31:4]; otherwise ERROR. addr[1:0] ignored.
REQ-020 ram_addr is driven combinationally from rq_data in every cycle; ram_we = rq_valid && rq_ready && iswrite && RAM decode.
REQ-021 RAM read accepted in cycle N: IDLE->RAM_RD; ram_rdata captured into the response register at the end of N+1; RESP with rs_valid=1 from N+2.
REQ-022 RAM write, MMIO access or ERROR accepted in cycle N: IDLE->RESP; rs_valid=1 from N+1.
REQ-023 Every accepted request, read or write, produces exactly one response; write responses carry rs_data = 0.
REQ-024 In RESP, rs_valid and rs_data are held stable until rs_ready=1; on handshake the FSM returns to IDLE, and rq_ready=1 the following cycle.
REQ-025 MMIO +0x0 GPIO_OUT: R/W, bits [7:0]; a write updates gpio_out from the following cycle; a read returns {24'b0, gpio_out}.
REQ-026 MMIO +0x4 GPIO_IN: read returns {24'b0, gpio_in} as sampled in the acceptance cycle; writes ignored.
REQ-027 MMIO +0x8 CYCLES: 32-bit free-running counter, +1 every cycle, wraps 0xFFFF_FFFF->0; read returns the value in the acceptance cycle; writes ignored.
REQ-028 MMIO +0xC ERRCNT: 8-bit count of ERROR requests, saturating at 255; read returns {24'b0, errcnt}; a write of any value clears it to 0.
REQ-029 ERROR request: no RAM or register side effect; response data 32'hDEAD_BEEF; errcnt increments (unless already 255).
REQ-030 Writes to read-only MMIO registers are not errors and do not touch errcnt.
REQ-031 rs_data shall be 0 whenever rs_valid = 0.

Reset
REQ-032 While RST_N=0 at a rising edge: state<=IDLE, rs_valid<=0, response register<=0, gpio_out<=0, cycles<=0, errcnt<=0.
REQ-033 During reset cycles rq_ready=0 and ram_we=0; rq_ready=1 in the first cycle after RST_N rises.
REQ-034 Reset in RAM_RD or RESP discards the pending response; no response is emitted for it after reset.

Verification
REQ-035 RAM preloaded word 5 = 32'h1234_5678; read addr 0x14 accepted at cycle N, rs_ready=1 -> rs_valid=1 at N+2 with rs_data=32'h1234_5678, rq_ready=1 at N+3.
REQ-036 Write addr 0x20, data 32'hCAFE_F00D -> ram_we=1 with ram_addr=8 in the acceptance cycle; response data 0 at N+1; a later read of 0x20 returns 32'hCAFE_F00D.
REQ-037 Write MMIO_BASE data 0xA5 -> gpio_out=8'hA5 next cycle; read MMIO_BASE -> 32'h0000_00A5; gpio_in=8'h3C, read +0x4 -> 32'h0000_003C.
REQ-038 Read 0x2000_0000 three times -> each response 32'hDEAD_BEEF; read +0xC -> 3; write +0xC then read +0xC -> 0; 300 errors -> read +0xC gives 255.
REQ-039 RAM read with rs_ready held 0 for 5 cycles -> rs_valid and rs_data stable, rq_ready=0 throughout; single handshake when rs_ready=1.
REQ-040 RST_N=0 asserted while in RAM_RD -> rs_valid=0 and gpio_out=0 after the edge, no stale response after release; cycle counter read shortly after release returns a small value consistent with restart from 0.
